// File: rtl/ifetch_prefetch_buffer.sv
// Instruction prefetch buffer: fetches sequential words into a small FIFO ahead of the
// IF stage and redirects on flush, discarding any memory response already in flight.
module ifetch_prefetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [31:0]            imem_addr,
    input  logic                   imem_ack,
    input  logic [31:0]            imem_rdata,
    input  logic                   flush,
    input  logic [31:0]            redirect_pc,
    input  logic                   if_we,
    output logic                   if_valid,
    output logic [31:0]            if_pc,
    output logic [31:0]            if_instr,
    output logic [1:0]             fsm_state,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    // Handshakes: imem_req stays high with imem_addr stable until an edge where
    // imem_req && imem_ack, which completes the transfer; the IF stage pops on an
    // edge where if_valid && if_we.

    state_t          state;
    state_t          state_n;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_after_pop;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [31:0]     fetch_pc;
    logic [31:0]     abandon_addr;
    logic [31:0]     pc_mem    [DEPTH];
    logic [31:0]     instr_mem [DEPTH];
    logic            pop;
    logic            push;

    assign fsm_state  = state;
    assign fifo_count = count;

    assign if_valid = (count != '0);
    assign if_pc    = if_valid ? pc_mem[rd_ptr]    : 32'd0;
    assign if_instr = if_valid ? instr_mem[rd_ptr] : 32'd0;

    assign imem_req  = (state == FETCH) || (state == DISCARD);
    assign imem_addr = (state == DISCARD) ? abandon_addr : fetch_pc;

    assign pop             = if_we && if_valid;
    assign count_after_pop = count - CW'(pop);

    always_comb begin
        state_n = state;
        push    = 1'b0;
        case (state)
            IDLE: begin
                // A request is only launched once a slot is guaranteed for its data.
                if (flush || (count_after_pop < FULL)) begin
                    state_n = FETCH;
                end
            end
            FETCH: begin
                if (flush) begin
                    state_n = imem_ack ? FETCH : DISCARD;
                end else if (imem_ack) begin
                    push    = 1'b1;
                    state_n = ((count_after_pop + CW'(1)) < FULL) ? FETCH : IDLE;
                end
            end
            DISCARD: begin
                if (imem_ack) begin
                    state_n = FETCH;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            count        <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            fetch_pc     <= RESET_PC;
            abandon_addr <= '0;
        end else begin
            state <= state_n;
            if (flush) begin
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                fetch_pc <= {redirect_pc[31:2], 2'b00};
            end else begin
                if (push) begin
                    wr_ptr   <= wr_ptr + PW'(1);
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count_after_pop + CW'(push);
            end
            // The in-flight address must stay on the bus until its ack retires it.
            if ((state == FETCH) && flush && !imem_ack) begin
                abandon_addr <= fetch_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= fetch_pc;
            instr_mem[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_ifetch_prefetch_buffer.sv
// Directed bench for ifetch_prefetch_buffer: fixed-latency memory responses driven cycle
// by cycle, with hand-computed addresses, FIFO heads and FSM states.
module tb_ifetch_prefetch_buffer;

    localparam logic [31:0] K        = 32'hA5A5_0000;
    localparam logic [31:0] S_IDLE   = 32'd0;
    localparam logic [31:0] S_FETCH  = 32'd1;
    localparam logic [31:0] S_DISC   = 32'd2;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        if_we;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [1:0]  fsm_state;
    logic [2:0]  fifo_count;

    int vectors;
    int miscompares;
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;

    ifetch_prefetch_buffer #(
        .DEPTH(4),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .flush(flush),
        .redirect_pc(redirect_pc),
        .if_we(if_we),
        .if_valid(if_valid),
        .if_pc(if_pc),
        .if_instr(if_instr),
        .fsm_state(fsm_state),
        .fifo_count(fifo_count)
    );

    // Memory returns a word derived from the requested address, so each entry's
    // data can be predicted from its PC.
    assign imem_rdata = imem_ack ? (imem_addr ^ K) : 32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ack, input logic we, input logic fl, input logic [31:0] rpc);
        imem_ack    = ack;
        if_we       = we;
        flush       = fl;
        redirect_pc = rpc;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0);

        // Reset state
        @(negedge clk);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_pc", if_pc, 32'd0);
        check("rst_instr", if_instr, 32'd0);
        check("rst_state", 32'(fsm_state), S_IDLE);
        check("rst_count", 32'(fifo_count), 32'd0);
        next_cycle();
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        check("release_req", 32'(imem_req), 32'd0);
        next_cycle();

        // Fill: zero-wait acks at 0,4,8,12 then stop at full
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("fill_req", 32'(imem_req), 32'd1);
            check("fill_addr", imem_addr, 32'(i * 4));
            next_cycle();
        end
        @(negedge clk);
        check("full_req", 32'(imem_req), 32'd0);
        check("full_state", 32'(fsm_state), S_IDLE);
        check("full_count", 32'(fifo_count), 32'd4);
        check("full_head_pc", if_pc, 32'd0);
        check("full_head_instr", if_instr, 32'h0000_0000 ^ K);

        // One pop at full reopens a slot and fetch resumes at 16
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        check("pop_head_pc", if_pc, 32'd4);
        check("pop_head_instr", if_instr, 32'h0000_0004 ^ K);
        check("pop_addr", imem_addr, 32'd16);
        check("pop_req", 32'(imem_req), 32'd1);
        check("pop_count", 32'(fifo_count), 32'd3);
        next_cycle();
        @(negedge clk);
        check("refull_req", 32'(imem_req), 32'd0);
        check("refull_count", 32'(fifo_count), 32'd4);

        // Flush in IDLE (with a same-cycle pop) to 0x8
        drive(1'b0, 1'b1, 1'b1, 32'h0000_0008);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        check("idle_flush_addr", imem_addr, 32'h8);
        check("idle_flush_req", 32'(imem_req), 32'd1);
        check("idle_flush_valid", 32'(if_valid), 32'd0);
        check("idle_flush_pc", if_pc, 32'd0);
        check("idle_flush_count", 32'(fifo_count), 32'd0);
        next_cycle();

        // Flush one cycle after the request to 0x8; ack arrives in the third request cycle
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0100);
        @(negedge clk);
        check("lat_addr_c2", imem_addr, 32'h8);
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        check("disc_state", 32'(fsm_state), S_DISC);
        check("disc_addr", imem_addr, 32'h8);
        check("disc_req", 32'(imem_req), 32'd1);
        check("disc_valid", 32'(if_valid), 32'd0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0020);
        @(negedge clk);
        check("redir_addr", imem_addr, 32'h100);
        check("redir_state", 32'(fsm_state), S_FETCH);
        check("redir_dropped", 32'(fifo_count), 32'd0);
        next_cycle();

        // 0x100 abandoned, move on to 0x20
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        check("disc2_addr", imem_addr, 32'h100);
        next_cycle();

        // Flush coincident with the ack at 0x20
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0200);
        @(negedge clk);
        check("coinc_addr", imem_addr, 32'h20);
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        check("coinc_next_addr", imem_addr, 32'h200);
        check("coinc_state", 32'(fsm_state), S_FETCH);
        check("coinc_no_push", 32'(if_valid), 32'd0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b1, 32'h0000_02F0);
        @(negedge clk);
        check("push200_pc", if_pc, 32'h200);
        check("push200_instr", if_instr, 32'h0000_0200 ^ K);
        check("push200_addr", imem_addr, 32'h204);
        next_cycle();

        // Two more flushes while in DISCARD; the last one (low bits set) wins
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0300);
        @(negedge clk);
        check("multi_state", 32'(fsm_state), S_DISC);
        check("multi_addr", imem_addr, 32'h204);
        check("multi_valid", 32'(if_valid), 32'd0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0402);
        @(negedge clk);
        check("multi2_state", 32'(fsm_state), S_DISC);
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        check("multi3_addr", imem_addr, 32'h204);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        check("multi_fetch_addr", imem_addr, 32'h400);
        check("multi_fetch_state", 32'(fsm_state), S_FETCH);
        check("multi_fetch_empty", 32'(fifo_count), 32'd0);

        // Reset mid-transaction, then a stray ack while held in reset and after release
        #2;
        rst = 1'b0;
        #1;
        check("midrst_req", 32'(imem_req), 32'd0);
        check("midrst_state", 32'(fsm_state), S_IDLE);
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        check("midrst_count", 32'(fifo_count), 32'd0);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ack_ignored", 32'(fifo_count), 32'd0);
        check("midrst_idle_req", 32'(imem_req), 32'd0);
        next_cycle();

        // Streaming: zero-wait acks, pop every cycle
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        @(negedge clk);
        check("stream_first_addr", imem_addr, 32'h0);
        check("stream_first_valid", 32'(if_valid), 32'd0);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(32'(i * 4));
        end
        next_cycle();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            exp_pc = exp_q.pop_front();
            check("stream_valid", 32'(if_valid), 32'd1);
            check("stream_pc", if_pc, exp_pc);
            check("stream_instr", if_instr, exp_pc ^ K);
            check("stream_addr", imem_addr, exp_pc + 32'd4);
            check("stream_count", 32'(fifo_count), 32'd1);
            next_cycle();
        end
        check("stream_queue_empty", 32'(exp_q.size()), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
